// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches one instruction per PC over req/ready and hands it to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        decode_ready,
  output logic        fetch_error
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERR} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d, fetch_error_q, fetch_error_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_error_d = fetch_error_q;
    wait_cnt_d    = wait_cnt_q;
    // A redirect beats any returning data or acceptance; only the error state ignores it.
    if (flush && state_q != S_ERR) begin
      pc_d          = flush_pc;
      instr_valid_d = 1'b0;
      wait_cnt_d    = '0;
      state_d       = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_REQ;
          wait_cnt_d = '0;
        end
        S_REQ: begin
          if (imem_ready) begin
            instr_d       = imem_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
          end else if (wait_cnt_q == 8'(MAX_WAIT - 1)) begin
            fetch_error_d = 1'b1;
            state_d       = S_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
        S_HOLD: begin
          if (decode_ready) begin
            pc_d          = next_pc;
            instr_valid_d = 1'b0;
            wait_cnt_d    = '0;
            state_d       = S_REQ;
          end
        end
        S_ERR:   instr_valid_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_error_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_error_q <= fetch_error_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign imem_req    = state_q == S_REQ;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_error = fetch_error_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: per-cycle vector table for fetch_stage plus a hand-written timeout sequence.
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset, flush, imem_ready, decode_ready;
  logic [31:0] next_pc, flush_pc, imem_data;
  logic [31:0] pc, imem_addr, instr, instr_pc;
  logic        imem_req, instr_valid, fetch_error;
  int          n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  fetch_stage #(.RESET_PC(32'd0), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset), .pc(pc), .next_pc(next_pc), .flush(flush),
    .flush_pc(flush_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .decode_ready(decode_ready),
    .fetch_error(fetch_error)
  );

  typedef struct {
    logic        rst, fl, rdy, dr;
    logic [31:0] fpc, dat, npc;
    logic [31:0] e_pc, e_ins, e_ipc;
    logic        e_req, e_iv, e_err;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic fl, logic [31:0] fpc, logic rdy, logic [31:0] dat,
                              logic dr, logic [31:0] npc, logic [31:0] e_pc, logic e_req,
                              logic [31:0] e_ins, logic [31:0] e_ipc, logic e_iv, logic e_err);
    vec_t v;
    v.rst = rst; v.fl = fl; v.fpc = fpc; v.rdy = rdy; v.dat = dat; v.dr = dr; v.npc = npc;
    v.e_pc = e_pc; v.e_req = e_req; v.e_ins = e_ins; v.e_ipc = e_ipc; v.e_iv = e_iv; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  initial begin
    int reqs;
    reset = 1; flush = 0; flush_pc = 0; imem_ready = 0; imem_data = 0; decode_ready = 0; next_pc = 0;
    //             rst fl fpc        rdy dat           dr npc           pc            req ins           ipc           iv err
    vq.push_back(mk(1, 0, 0,         0, 0,            0, 0,            0,            0, 0,            0,            0, 0));
    vq.push_back(mk(0, 0, 0,         0, 0,            0, 0,            0,            1, 0,            0,            0, 0));
    vq.push_back(mk(0, 0, 0,         1, 32'h2008000A, 0, 0,            0,            0, 32'h2008000A, 0,            1, 0));
    vq.push_back(mk(0, 0, 0,         0, 0,            1, 1,            1,            1, 32'h2008000A, 0,            0, 0));
    vq.push_back(mk(0, 0, 0,         1, 32'h11,       1, 32'h99,       1,            0, 32'h11,       1,            1, 0));
    vq.push_back(mk(0, 0, 0,         1, 0,            1, 2,            2,            1, 32'h11,       1,            0, 0));
    vq.push_back(mk(0, 0, 0,         1, 32'h22,       1, 0,            2,            0, 32'h22,       2,            1, 0));
    vq.push_back(mk(0, 0, 0,         1, 0,            1, 3,            3,            1, 32'h22,       2,            0, 0));
    vq.push_back(mk(0, 0, 0,         1, 32'h33,       0, 0,            3,            0, 32'h33,       3,            1, 0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 0, 0,       1, 32'hEE,       0, 32'h55 + i,   3,            0, 32'h33,       3,            1, 0));
    vq.push_back(mk(0, 0, 0,         0, 0,            1, 32'h20,       32'h20,       1, 32'h33,       3,            0, 0));
    vq.push_back(mk(0, 0, 0,         0, 0,            0, 0,            32'h20,       1, 32'h33,       3,            0, 0));
    vq.push_back(mk(0, 1, 32'h40,    1, 32'hDEAD,     0, 0,            32'h40,       0, 32'h33,       3,            0, 0));
    vq.push_back(mk(0, 0, 0,         0, 0,            0, 0,            32'h40,       1, 32'h33,       3,            0, 0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0, 0, 0,       0, 0,            0, 0,            32'h40,       1, 32'h33,       3,            0, 0));
    vq.push_back(mk(0, 0, 0,         0, 0,            0, 0,            32'h40,       0, 32'h33,       3,            0, 1));
    vq.push_back(mk(0, 1, 32'h100,   0, 0,            0, 0,            32'h40,       0, 32'h33,       3,            0, 1));
    vq.push_back(mk(0, 0, 0,         1, 32'h77,       1, 32'h5,        32'h40,       0, 32'h33,       3,            0, 1));
    vq.push_back(mk(1, 0, 0,         0, 0,            0, 0,            0,            0, 0,            0,            0, 0));
    vq.push_back(mk(0, 0, 0,         0, 0,            0, 0,            0,            1, 0,            0,            0, 0));
    vq.push_back(mk(0, 0, 0,         1, 32'hABC,      0, 0,            0,            0, 32'hABC,      0,            1, 0));
    vq.push_back(mk(1, 0, 0,         0, 0,            0, 32'h7,        0,            0, 0,            0,            0, 0));
    vq.push_back(mk(0, 0, 0,         0, 0,            0, 0,            0,            1, 0,            0,            0, 0));
    vq.push_back(mk(0, 0, 0,         1, 32'h77,       0, 0,            0,            0, 32'h77,       0,            1, 0));
    vq.push_back(mk(0, 1, 32'h200,   0, 0,            1, 32'h300,      32'h200,      0, 32'h77,       0,            0, 0));
    vq.push_back(mk(0, 0, 0,         0, 0,            0, 0,            32'h200,      1, 32'h77,       0,            0, 0));
    vq.push_back(mk(0, 0, 0,         1, 32'h5,        0, 0,            32'h200,      0, 32'h5,        32'h200,      1, 0));
    vq.push_back(mk(0, 0, 0,         0, 0,            1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h5,        32'h200,      0, 0));
    vq.push_back(mk(0, 0, 0,         1, 32'h6,        0, 0,            32'hFFFFFFFF, 0, 32'h6,        32'hFFFFFFFF, 1, 0));
    vq.push_back(mk(0, 0, 0,         0, 0,            1, 32'h0,        32'h0,        1, 32'h6,        32'hFFFFFFFF, 0, 0));
    foreach (vq[i]) begin
      @(negedge clock);
      reset = vq[i].rst; flush = vq[i].fl; flush_pc = vq[i].fpc; imem_ready = vq[i].rdy;
      imem_data = vq[i].dat; decode_ready = vq[i].dr; next_pc = vq[i].npc;
      @(posedge clock); #1;
      chk("pc", i, pc, vq[i].e_pc);
      chk("imem_addr", i, imem_addr, vq[i].e_pc);
      chk("imem_req", i, 32'(imem_req), 32'(vq[i].e_req));
      chk("instr", i, instr, vq[i].e_ins);
      chk("instr_pc", i, instr_pc, vq[i].e_ipc);
      chk("instr_valid", i, 32'(instr_valid), 32'(vq[i].e_iv));
      chk("fetch_error", i, 32'(fetch_error), 32'(vq[i].e_err));
    end
    // Timeout from a fresh reset: count request cycles until the error flag, bounded.
    @(negedge clock);
    reset = 1; flush = 0; imem_ready = 0; decode_ready = 0;
    @(negedge clock);
    reset = 0;
    reqs = 0;
    for (int c = 0; c < 20 && !fetch_error; c++) begin
      @(negedge clock);
      if (imem_req) reqs++;
    end
    chk("timeout_seen", 100, 32'(fetch_error), 32'd1);
    chk("timeout_req_cycles", 100, 32'(reqs), 32'd4);
    chk("timeout_req_low", 100, 32'(imem_req), 32'd0);
    repeat (3) @(negedge clock);
    chk("error_sticky", 101, 32'(fetch_error), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
